// File: rtl/booth_multiplier.sv
// Multi-cycle signed radix-2 Booth multiplier: one add/sub + arithmetic shift per clock, 32 iterations.
// A start pulse in any state restarts the operation; result/exception are held until the next completion.
module booth_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PW = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [PW-1:0]    r_prod;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;

  logic [WIDTH:0]   w_phi_ext;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_prod_nxt;
  logic [WIDTH-1:0] w_phi_nxt;
  logic [WIDTH-1:0] w_plo_nxt;
  logic             w_last;

  // One extra sign bit keeps the add/sub exact even for M = most-negative value.
  assign w_phi_ext = {r_prod[PW-1], r_prod[PW-1:WIDTH+1]};
  assign w_m_ext   = {r_m[WIDTH-1], r_m};

  always_comb begin
    w_sum = w_phi_ext;
    case (r_prod[1:0])
      2'b01:   w_sum = w_phi_ext + w_m_ext;
      2'b10:   w_sum = w_phi_ext - w_m_ext;
      default: w_sum = w_phi_ext;
    endcase
  end

  // Arithmetic shift of {sum, P_lo, q_m1} by one, keeping the low 2*WIDTH+1 bits.
  assign w_prod_nxt = {w_sum, r_prod[WIDTH:1]};
  assign w_phi_nxt  = w_prod_nxt[PW-1:WIDTH+1];
  assign w_plo_nxt  = w_prod_nxt[WIDTH:1];
  assign w_last     = (r_count == LAST_CNT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (ctrl_MULT) w_state_nxt = RUN;
      RUN: begin
        if (ctrl_MULT)   w_state_nxt = RUN;
        else if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = ctrl_MULT ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count  <= '0;
      r_prod   <= '0;
      r_m      <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else if (ctrl_MULT) begin
      r_m     <= data_operandA;
      r_prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      r_count <= '0;
      r_rdy   <= 1'b0;
    end else if (r_state == RUN) begin
      r_prod  <= w_prod_nxt;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_result <= w_plo_nxt;
        r_exc    <= (w_phi_nxt != {WIDTH{w_plo_nxt[WIDTH-1]}});
        r_rdy    <= 1'b1;
      end else begin
        r_rdy <= 1'b0;
      end
    end else begin
      r_rdy <= 1'b0;
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state == RUN);

endmodule

// File: tb/tb_booth_multiplier.sv
// Bench for booth_multiplier: directed corner products, random products, restart, collision and reset cases.
module tb_booth_multiplier;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  booth_multiplier #(.WIDTH(32), .CNT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision signed product, low word and a fits-in-32-bit test.
  function automatic logic [32:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic               exc;
    p   = 64'($signed(a)) * 64'($signed(b));
    exc = (p != {{32{p[31]}}, p[31:0]});
    return {exc, p[31:0]};
  endfunction

  // Called at a negedge: presents a start pulse for exactly one rising edge, then scrambles operands.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called one negedge after the start edge; returns negedges counted since that edge when RDY seen.
  task automatic wait_rdy(output int lat);
    lat = 1;
    while (!data_resultRDY && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] exp;
    int          lat;
    exp = ref_mult(a, b);
    @(negedge clock);
    start_op(a, b);
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    wait_rdy(lat);
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_result"}, data_result, exp[31:0]);
    check({tag, "_exc"}, 32'(data_exception), 32'(exp[32]));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(negedge clock);
    check({tag, "_rdy_pulse"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    int          lat;
    int          pulses;
    logic [31:0] seen_res;
    logic [31:0] ra, rb;

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_result", data_result, 32'd0);
    check("rst_exc", 32'(data_exception), 32'd0);
    check("rst_rdy", 32'(data_resultRDY), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_mult("m3x4", 32'd3, 32'd4);
    check("m3x4_value", data_result, 32'h0000000C);
    run_mult("mneg7x6", 32'hFFFFFFF9, 32'd6);
    check("mneg7x6_value", data_result, 32'hFFFFFFD6);
    run_mult("mneg1xneg1", 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mult("mminxneg1", 32'h80000000, 32'hFFFFFFFF);
    check("mminxneg1_exc", 32'(data_exception), 32'd1);
    run_mult("m2p16sq", 32'h00010000, 32'h00010000);
    run_mult("mminxmin", 32'h80000000, 32'h80000000);
    check("mminxmin_exc", 32'(data_exception), 32'd1);
    run_mult("mmaxx1", 32'h7FFFFFFF, 32'd1);
    run_mult("m0xmin", 32'd0, 32'h80000000);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = 32'($signed(16'($urandom)));
      if (i % 4 == 1) rb = 32'($signed(16'($urandom)));
      run_mult($sformatf("rnd%0d", i), ra, rb);
    end

    // Restart mid-run: first operation abandoned, only the second reports.
    run_mult("pre_restart", 32'd11, 32'd3);
    @(negedge clock);
    start_op(32'd5, 32'd5);
    repeat (9) @(negedge clock);
    check("restart_hold_result", data_result, 32'd33);
    start_op(32'd2, 32'd9);
    pulses = 0;
    lat = 0;
    seen_res = 32'd0;
    for (int j = 1; j <= 45; j++) begin
      if (data_resultRDY) begin
        pulses++;
        if (lat == 0) begin
          lat = j;
          seen_res = data_result;
        end
      end
      @(negedge clock);
    end
    check("restart_pulses", 32'(pulses), 32'd1);
    check("restart_latency", 32'(lat), 32'd33);
    check("restart_result", seen_res, 32'd18);

    // Start on the same edge as the final iteration: no RDY, old result kept.
    @(negedge clock);
    start_op(32'd100, 32'd7);
    repeat (31) @(negedge clock);
    check("collide_pre_rdy", 32'(data_resultRDY), 32'd0);
    start_op(32'hFFFFFFFD, 32'd8);
    check("collide_no_rdy", 32'(data_resultRDY), 32'd0);
    check("collide_old_result", data_result, 32'd18);
    check("collide_busy", 32'(busy), 32'd1);
    wait_rdy(lat);
    check("collide_latency", 32'(lat), 32'd33);
    check("collide_result", data_result, 32'hFFFFFFE8);

    // Synchronous reset mid-run.
    @(negedge clock);
    start_op(32'd7, 32'd9);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_result", data_result, 32'd0);
    check("midrst_exc", 32'(data_exception), 32'd0);
    check("midrst_rdy", 32'(data_resultRDY), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      if (data_resultRDY) pulses++;
      @(negedge clock);
    end
    check("midrst_no_rdy", 32'(pulses), 32'd0);
    run_mult("post_rst_3x4", 32'd3, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
